// File: rtl/ex_stage_register.sv
// Execute stage: ALU on ID/EX operands, registered into EX/MEM, and owner of the carry/zero flags.
// Stall holds everything; flush inserts a bubble but leaves the flags alone.
module ex_stage_register #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         alu_ctrl,
  input  logic               id_ex_valid,
  input  logic [DATA_W-1:0]  id_ex_opa,
  input  logic [DATA_W-1:0]  id_ex_opb,
  input  logic [DATA_W-1:0]  id_ex_imm,
  input  logic               id_ex_use_imm,
  input  logic [RADDR_W-1:0] id_ex_rd,
  input  logic               id_ex_reg_write,
  input  logic               id_ex_set_flags,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_mem_valid,
  output logic [DATA_W-1:0]  ex_mem_result,
  output logic [RADDR_W-1:0] ex_mem_rd,
  output logic               ex_mem_reg_write,
  output logic               carry_flag,
  output logic               zero_flag
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic [DATA_W-1:0] opb_sel;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_result;
  logic              flag_update;

  assign opb_sel     = id_ex_use_imm ? id_ex_imm : id_ex_opb;
  assign sum         = {1'b0, id_ex_opa} + {1'b0, opb_sel};
  assign flag_update = id_ex_valid & id_ex_set_flags;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      OP_AND:  alu_result = id_ex_opa & opb_sel;
      OP_OR:   alu_result = id_ex_opa | opb_sel;
      OP_ADD:  alu_result = sum[DATA_W-1:0];
      OP_NAND: alu_result = ~(id_ex_opa & opb_sel);
      default: alu_result = '0;
    endcase
  end

  // Priority: rst > flush > stall > load; flags move only on a valid flag-setting load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_valid     <= 1'b0;
      ex_mem_result    <= '0;
      ex_mem_rd        <= '0;
      ex_mem_reg_write <= 1'b0;
      carry_flag       <= 1'b0;
      zero_flag        <= 1'b0;
    end else if (flush) begin
      ex_mem_valid     <= 1'b0;
      ex_mem_result    <= '0;
      ex_mem_rd        <= '0;
      ex_mem_reg_write <= 1'b0;
    end else if (!stall) begin
      ex_mem_valid     <= id_ex_valid;
      ex_mem_result    <= alu_result;
      ex_mem_rd        <= id_ex_rd;
      ex_mem_reg_write <= id_ex_reg_write & id_ex_valid;
      if (flag_update) begin
        zero_flag <= (alu_result == '0);
        if (alu_ctrl == OP_ADD) carry_flag <= sum[DATA_W];
      end
    end
  end

endmodule

// File: doc/ex_stage_register.md
Name: ex_stage_register

Overview:
- Execute stage of the 4-op pipelined RISC core, directly downstream of the ALU control decoder.
- Consumes the 2-bit ALU control signal and ID/EX operands, computes the result, and registers it into the EX/MEM pipeline register.
- Owns the architectural carry and zero flags.
- Supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 16, datapath width of operands and result.
- RADDR_W, 3, destination register index width.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_ctrl  input  2  from ALU control: 00 AND, 01 OR (ORI), 10 ADD, 11 NAND.
- id_ex_valid  input  1  ID/EX slot holds a real instruction.
- id_ex_opa  input  DATA_W  operand A (already forwarded).
- id_ex_opb  input  DATA_W  operand B register value (already forwarded).
- id_ex_imm  input  DATA_W  sign/zero-extended immediate.
- id_ex_use_imm  input  1  1 selects id_ex_imm as B.
- id_ex_rd  input  RADDR_W  destination register.
- id_ex_reg_write  input  1  instruction writes rd.
- id_ex_set_flags  input  1  instruction updates flags.
- stall  input  1  hold EX/MEM contents and flags.
- flush  input  1  replace incoming instruction with a bubble.
- ex_mem_valid  output  1  registered valid.
- ex_mem_result  output  DATA_W  registered ALU result.
- ex_mem_rd  output  RADDR_W  registered destination.
- ex_mem_reg_write  output  1  registered write enable, forced 0 when not valid.
- carry_flag  output  1  architectural carry.
- zero_flag  output  1  architectural zero.

Behaviour:
- Reset: synchronous, active-high. On a rising edge with rst=1, every output is cleared to 0: ex_mem_valid, ex_mem_result, ex_mem_rd, ex_mem_reg_write, carry_flag, zero_flag.
- Operand B: B = id_ex_use_imm ? id_ex_imm : id_ex_opb.
- ALU (combinational, internal):
  - 00: A & B.
  - 01: A | B.
  - 10: A + B, truncated to DATA_W. Carry-out is bit DATA_W of the (DATA_W+1)-bit sum.
  - 11: ~(A & B).
- Latency: 1 cycle. The result appears on ex_mem_* at the edge after the inputs are presented.
- Update priority per edge: rst > flush > stall > load.
  - flush=1: ex_mem_valid=0, ex_mem_reg_write=0, ex_mem_result=0, ex_mem_rd=0. Flags unchanged. Flush wins over a simultaneous stall.
  - stall=1 (no flush): all outputs, including flags, hold their values.
  - Load: ex_mem_valid <= id_ex_valid, ex_mem_result <= ALU result, ex_mem_rd <= id_ex_rd, ex_mem_reg_write <= id_ex_reg_write & id_ex_valid.
- Flag update happens only on a load with id_ex_valid=1 and id_ex_set_flags=1:
  - zero_flag <= (result == 0) for all four ops.
  - carry_flag <= carry-out for ADD only; holds for AND, OR and NAND.
- Invalid slot (id_ex_valid=0, load): bubble propagates. Result is still registered but reg_write=0; flags untouched.
- ADD wrap-around: 0xFFFF + 0x0001 gives result 0x0000, carry 1, zero 1.
- Reset asserted mid-stall or mid-flush: reset wins; outputs clear on that edge.
- There is no combinational path from stall or flush to any output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> all outputs 0. Release rst; with valid=0, outputs stay 0.
- ADD with overflow: alu_ctrl=10, A=0xFFFF, opb=0x0001, use_imm=0, set_flags=1, rd=3, reg_write=1 -> next cycle result=0x0000, carry=1, zero=1, rd=3, reg_write=1, valid=1.
- Flag selectivity:
  - ORI with use_imm=1, A=0x00F0, imm=0x000F, opb=0xFFFF, set_flags=1 -> result=0x00FF, zero=0, carry unchanged from previous value 1.
  - NAND A=0xFFFF, B=0xFFFF -> result=0x0000, zero=1.
- Stall: load AND 0x0F0F & 0x00FF (=0x000F), then assert stall for 3 cycles while presenting ADD 1+1 -> outputs stay 0x000F and flags stay unchanged. Deassert stall -> next edge result=0x0002.
- Flush, including flush+stall: valid ADD 5+5 with set_flags=1, flush=1 and stall=1 together -> valid=0, reg_write=0, result=0, flags unchanged.
- Bubble: id_ex_valid=0, reg_write=1, set_flags=1, ADD 0+0 -> ex_mem_reg_write=0, valid=0, zero_flag unchanged.
